buffer_arbiter: RTL and testbench

BUFFER_ARBITER -- requirements
Module: buffer_arbiter

---
 rtl/buffer_pkg.sv | 14 +
 rtl/buf_ptr.sv | 25 ++
 rtl/buffer_arbiter.sv | 170 +++++++++++++++++
 tb/tb_buffer_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared constants and read-FSM state type for the capture buffer arbiter.
package buffer_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/buf_ptr.sv
// Wrapping ring-buffer pointer; rolls over from all-ones to zero on increment.
module buf_ptr
    import buffer_pkg::*;
#(
    parameter int PTR_W = buffer_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/buffer_arbiter.sv
// Single-port RAM arbiter for a capture ring buffer: writes always win, reads wait in PEND.
// Define BUF_OVERWRITE_EN to let writes into a full buffer evict the oldest word.
module buffer_arbiter #(
    parameter int DATA_W = buffer_pkg::DATA_W,
    parameter int ADDR_W = buffer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    import buffer_pkg::*;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    rd_state_t         r_state;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_ready;
    logic              w_accept;
    logic              w_wr_fire;
    logic              w_wr_evict;
    logic              w_rd_issue;
    logic              w_rd_adv;
    logic              w_cnt_inc;
    logic              w_cnt_dec;
    logic              w_ovf_set;
    logic              w_unf_set;

    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == FULL_CNT);
        w_rd_ready = (r_state == ST_IDLE) && !w_empty;
        w_accept   = rd_req && w_rd_ready;

        // Reset suppresses any RAM write in the same cycle.
`ifdef BUF_OVERWRITE_EN
        w_wr_fire  = !rst && wr_req;
        w_wr_evict = w_wr_fire && w_full;
`else
        w_wr_fire  = !rst && wr_req && !w_full;
        w_wr_evict = 1'b0;
`endif

        w_rd_issue = !rst && !wr_req &&
                     (((r_state == ST_IDLE) && w_accept) || (r_state == ST_PEND));
        w_rd_adv   = w_rd_issue || w_wr_evict;

        // An eviction replaces the oldest word, so the fill level stays put.
        w_cnt_inc  = w_wr_fire && !w_wr_evict;
        w_cnt_dec  = w_rd_issue;

        w_ovf_set  = wr_req && w_full;
        w_unf_set  = rd_req && w_empty && (r_state == ST_IDLE);
    end

    buf_ptr #(
        .PTR_W (ADDR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_fire),
        .o_ptr (w_wr_ptr)
    );

    buf_ptr #(
        .PTR_W (ADDR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_adv),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= wr_req ? ST_PEND : ST_DATA;
                    end
                end
                ST_PEND: begin
                    if (!wr_req) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_rd_data  <= ram_rdata;
                    r_rd_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            r_count <= r_count + (ADDR_W+1)'(1);
        end else if (!w_cnt_inc && w_cnt_dec) begin
            r_count <= r_count - (ADDR_W+1)'(1);
        end
    end

    // Sticky flags: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign ram_we    = w_wr_fire;
    assign ram_addr  = w_wr_fire ? w_wr_ptr : w_rd_ptr;
    assign ram_wdata = wr_data;

    assign rd_ready  = w_rd_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_buffer_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int DEPTH = 1 << AW;
`ifdef BUF_OVERWRITE_EN
    localparam bit OW = 1'b1;
`else
    localparam bit OW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic          clr_err = 1'b0;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    buffer_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-first, one-cycle registered read.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer contents as a queue, plus the read request's progress.
    logic [DW-1:0] m_q[$];
    int            m_wp, m_rp;
    bit            m_wait, m_fetch, m_vld, m_ovf, m_unf, m_init;
    logic [DW-1:0] m_rdata, m_fetch_word;

    task automatic model_reset();
        m_q.delete();
        m_wp = 0; m_rp = 0;
        m_wait = 0; m_fetch = 0; m_vld = 0;
        m_ovf = 0; m_unf = 0;
        m_rdata = '0;
    endtask

    always @(negedge clk) begin : compare
        bit ready, accept, exp_we, issue, ovf_set, unf_set;
        if (!m_init) begin
            if (rst) begin
                model_reset();
                m_init = 1'b1;
            end
        end else begin
            ready   = !m_wait && !m_fetch && (m_q.size() > 0);
            accept  = rd_req && ready;
            exp_we  = !rst && wr_req && ((m_q.size() < DEPTH) || OW);
            issue   = !rst && !wr_req && (accept || m_wait);
            ovf_set = wr_req && (m_q.size() == DEPTH);
            unf_set = rd_req && (m_q.size() == 0) && !m_wait && !m_fetch;

            chk("rd_ready", 32'(rd_ready), 32'(ready));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            chk("ram_addr", 32'(ram_addr), 32'(exp_we ? m_wp : m_rp));
            if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(wr_data));
            chk("count", 32'(count), 32'(m_q.size()));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("rd_valid", 32'(rd_valid), 32'(m_vld));
            chk("rd_data", 32'(rd_data), 32'(m_rdata));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));

            if (rst) begin
                model_reset();
            end else begin
                m_vld = m_fetch;
                if (m_fetch) m_rdata = m_fetch_word;
                m_fetch = 1'b0;
                if (issue) begin
                    m_fetch_word = m_q.pop_front();
                    m_rp   = (m_rp + 1) % DEPTH;
                    m_fetch = 1'b1;
                    m_wait  = 1'b0;
                end else if (accept) begin
                    m_wait = 1'b1;
                end
                if (exp_we) begin
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_rp = (m_rp + 1) % DEPTH;
                    end
                    m_q.push_back(wr_data);
                    m_wp = (m_wp + 1) % DEPTH;
                end
                m_ovf = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
                m_unf = unf_set ? 1'b1 : (clr_err ? 1'b0 : m_unf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_req = 1'b1; wr_data = d;
        tick();
        wr_req = 1'b0;
    endtask

    // Uncontended read: accept, one DATA cycle, then the valid strobe.
    task automatic read_word(input string name, input logic [DW-1:0] exp);
        chk({name, "_ready"}, 32'(rd_ready), 32'd1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({name, "_early"}, 32'(rd_valid), 32'd0);
        tick();
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data), 32'(exp));
        $display("read %s: data=0x%04h valid=%0b count=%0d", name, rd_data, rd_valid, count);
    endtask

    function automatic logic [DW-1:0] fill_word(input int i);
        return DW'(i) ^ 16'hA5A5;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // Three writes, three reads, each valid two cycles after accept.
        write_word(16'h1111);
        write_word(16'h2222);
        write_word(16'h3333);
        chk("t1_count3", 32'(count), 32'd3);
        read_word("t1_r0", 16'h1111);
        read_word("t1_r1", 16'h2222);
        read_word("t1_r2", 16'h3333);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        tick();
        chk("t1_hold_valid", 32'(rd_valid), 32'd0);
        chk("t1_hold_data", 32'(rd_data), 32'h3333);

        // Read accepted during three back-to-back writes waits in PEND.
        write_word(16'h5A5A);
        rd_req = 1'b1; wr_req = 1'b1; wr_data = 16'h0001;
        tick();
        rd_req = 1'b0; wr_data = 16'h0002;
        tick();
        wr_data = 16'h0003;
        tick();
        wr_req = 1'b0;
        chk("t2_pend_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("t2_issue_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(rd_valid), 32'd1);
        chk("t2_data", 32'(rd_data), 32'h5A5A);
        chk("t2_count", 32'(count), 32'd3);
        $display("read t2: data=0x%04h after contention", rd_data);
        read_word("t2_w1", 16'h0001);
        read_word("t2_w2", 16'h0002);
        read_word("t2_w3", 16'h0003);

        // Read on empty: ignored, underflow set, then cleared.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t3_novalid0", 32'(rd_valid), 32'd0);
        tick();
        chk("t3_novalid1", 32'(rd_valid), 32'd0);
        chk("t3_underflow", 32'(underflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_cleared", 32'(underflow), 32'd0);
        $display("underflow test: underflow=%0b", underflow);

        // Reset while the read sits in its DATA cycle, with a write asserted.
        write_word(16'hBEEF);
        write_word(16'hCAFE);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rst = 1'b1; wr_req = 1'b1; wr_data = 16'hDEAD;
        #1;
        chk("t4_no_we", 32'(ram_we), 32'd0);
        tick();
        rst = 1'b0; wr_req = 1'b0;
        chk("t4_valid", 32'(rd_valid), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_rd_data", 32'(rd_data), 32'd0);
        tick();
        chk("t4_valid_late", 32'(rd_valid), 32'd0);
        $display("reset-in-DATA test: count=%0d rd_valid=%0b", count, rd_valid);

        // Fill past capacity; the last write hits address DEPTH-1 before wrapping.
        for (int i = 0; i <= DEPTH; i++) begin
            wr_req = 1'b1; wr_data = fill_word(i);
            #1;
            if (i == DEPTH - 1) begin
                chk("t5_last_addr", 32'(ram_addr), 32'(DEPTH - 1));
                chk("t5_last_we", 32'(ram_we), 32'd1);
            end
            if (i == DEPTH) chk("t5_extra_we", 32'(ram_we), 32'(OW));
            tick();
            if (i == DEPTH - 1) begin
                chk("t5_full", 32'(full), 32'd1);
                chk("t5_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        wr_req = 1'b0;
        chk("t5_count", 32'(count), 32'(DEPTH));
        chk("t5_overflow", 32'(overflow), 32'd1);
        $display("fill test: count=%0d full=%0b overflow=%0b", count, full, overflow);
        read_word("t5_first", OW ? fill_word(1) : fill_word(0));
        wr_req = 1'b1; wr_data = 16'h1234;
        #1;
        chk("t5_wrap_addr", 32'(ram_addr), OW ? 32'd1 : 32'd0);
        tick();
        wr_req = 1'b0;

        // Randomized traffic with occasional resets, checked by the model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            wr_req  = ($urandom_range(0, 99) < 45);
            rd_req  = ($urandom_range(0, 99) < 50);
            clr_err = ($urandom_range(0, 99) < 5);
            rst     = ($urandom_range(0, 299) == 0);
            wr_data = DW'($urandom);
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; rst = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
